// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the microprogrammed control sequencer.
// Latency: n/a (types, constants and a pure dispatch function only).
// Backpressure: n/a.
package control_sequencer_pkg;

  // Micro-address map (the 16-word control store is indexed by these)
  typedef enum logic [3:0] {
    U_IDLE   = 4'd0,
    U_FETCH  = 4'd1,
    U_DECODE = 4'd2,
    U_INCR   = 4'd3,
    U_HALT   = 4'd4,
    U_LDA    = 4'd5,
    U_STA    = 4'd6,
    U_ADD    = 4'd7,
    U_SUB    = 4'd8,
    U_AND    = 4'd9,
    U_LDI    = 4'd10,
    U_JMP_EX = 4'd11,
    U_JZ_EX  = 4'd12
  } uaddr_t;

  // Opcodes; 9..14 are reserved and behave as NOP
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_STA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LDI = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  // ALU operand-source encodings for cu_A / cu_B
  localparam logic [1:0] SRC_R       = 2'd0;
  localparam logic [1:0] SRC_DMEM    = 2'd1;
  localparam logic [1:0] SRC_OPERAND = 2'd2;
  localparam logic [1:0] SRC_ZERO    = 2'd3;

  // Control-word layout: {HLT, INC, REPC, REIR, REDMEM, RER, cu_A, cu_B}
  localparam int CW_W      = 10;
  localparam int CW_HLT    = 9;
  localparam int CW_INC    = 8;
  localparam int CW_REPC   = 7;
  localparam int CW_REIR   = 6;
  localparam int CW_REDMEM = 5;
  localparam int CW_RER    = 4;
  localparam int CW_A_LSB  = 2;
  localparam int CW_B_LSB  = 0;

  // Opcode -> first execute micro-address
  function automatic uaddr_t dispatch(input logic [3:0] op);
    uaddr_t tgt;
    case (op)
      OP_LDA:  tgt = U_LDA;
      OP_STA:  tgt = U_STA;
      OP_ADD:  tgt = U_ADD;
      OP_SUB:  tgt = U_SUB;
      OP_AND:  tgt = U_AND;
      OP_LDI:  tgt = U_LDI;
      OP_JMP:  tgt = U_JMP_EX;
      OP_JZ:   tgt = U_JZ_EX;
      OP_HLT:  tgt = U_HALT;
      default: tgt = U_INCR;   // NOP and reserved opcodes
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/control_sequencer_rom.sv
// Control store: 16 x 10-bit combinational lookup from micro-address to control word.
// Latency: 0 cycles (pure combinational decode).
// Backpressure: none.
// Ports: uaddr (4) in -> cw (10) out = {HLT, INC, REPC, REIR, REDMEM, RER, cu_A[1:0], cu_B[1:0]}.
module control_sequencer_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0]      uaddr,
  output logic [CW_W-1:0] cw
);

  always_comb begin
    cw = '0;
    case (uaddr)
      U_FETCH: cw[CW_REIR] = 1'b1;
      U_INCR:  cw[CW_INC]  = 1'b1;
      U_HALT:  cw[CW_HLT]  = 1'b1;
      U_LDA: begin
        cw[CW_RER] = 1'b1;
        cw[CW_A_LSB +: 2] = SRC_DMEM;
        cw[CW_B_LSB +: 2] = SRC_ZERO;
      end
      U_STA:   cw[CW_REDMEM] = 1'b1;
      U_ADD, U_SUB, U_AND: begin
        cw[CW_RER] = 1'b1;
        cw[CW_A_LSB +: 2] = SRC_R;
        cw[CW_B_LSB +: 2] = SRC_DMEM;
      end
      U_LDI: begin
        cw[CW_RER] = 1'b1;
        cw[CW_A_LSB +: 2] = SRC_OPERAND;
        cw[CW_B_LSB +: 2] = SRC_ZERO;
      end
      // The datapath chooses target vs pc+1; the sequencer just enables both
      U_JMP_EX, U_JZ_EX: begin
        cw[CW_REPC] = 1'b1;
        cw[CW_INC]  = 1'b1;
      end
      default: cw = '0;   // IDLE, DECODE and unused words 13..15
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microprogrammed control unit: steps fetch/decode/execute and drives datapath enables.
// Latency: Moore; outputs decode from registered uaddr (3-4 cycles per instruction).
// Backpressure: run gates new instructions at IDLE/instruction end; never aborts one in flight.
// Ports: clk, reset_cu_n (async low), run, ir_opcode[3:0] in;
//        HLT, INC, REPC, REIR, REDMEM, RER, cu_A[1:0], cu_B[1:0], uaddr[3:0], instr_done out.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_cu_n,
  input  logic       run,
  input  logic [3:0] ir_opcode,
  output logic       HLT,
  output logic       INC,
  output logic       REPC,
  output logic       REIR,
  output logic       REDMEM,
  output logic       RER,
  output logic [1:0] cu_A,
  output logic [1:0] cu_B,
  output logic [3:0] uaddr,
  output logic       instr_done
);

  uaddr_t          state_q;
  uaddr_t          state_d;
  logic [CW_W-1:0] cw;

  always_ff @(posedge clk or negedge reset_cu_n) begin
    if (!reset_cu_n) state_q <= U_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = U_IDLE;
    case (state_q)
      U_IDLE:   state_d = run ? U_FETCH : U_IDLE;
      U_FETCH:  state_d = U_DECODE;
      // ir_opcode matters only here; the IR was loaded at the end of FETCH
      U_DECODE: state_d = dispatch(ir_opcode);
      U_INCR, U_JMP_EX, U_JZ_EX:
                state_d = run ? U_FETCH : U_IDLE;
      U_HALT:   state_d = U_HALT;   // sticky until reset
      U_LDA, U_STA, U_ADD, U_SUB, U_AND, U_LDI:
                state_d = U_INCR;
      default:  state_d = U_IDLE;
    endcase
  end

  assign uaddr = state_q;

  control_sequencer_rom u_rom (
    .uaddr (state_q),
    .cw    (cw)
  );

  assign HLT    = cw[CW_HLT];
  assign INC    = cw[CW_INC];
  assign REPC   = cw[CW_REPC];
  assign REIR   = cw[CW_REIR];
  assign REDMEM = cw[CW_REDMEM];
  assign RER    = cw[CW_RER];
  assign cu_A   = cw[CW_A_LSB +: 2];
  assign cu_B   = cw[CW_B_LSB +: 2];

  // Final cycle of every instruction: INCR, or the single jump execute cycle
  assign instr_done = (state_q == U_INCR) || (state_q == U_JMP_EX) ||
                      (state_q == U_JZ_EX);

endmodule
